bcd_to_bin: RTL and testbench
=============================

Name: bcd_to_bin

Overview:
- Sequential converter from packed multi-digit BCD to unsigned binary, using iterative reverse double-dabble (shift right, then subtract 3 from each digit ≥ 8).
- It is the inverse of the team's binary→BCD decoder path. It takes digits captured from switches or display logic and returns their binary value for arithmetic blocks.
- Uses a start/busy/done handshake. One bit is resolved per clock cycle.

Parameters:
- DIGITS, 2, number of BCD digits in bcd_in; digit 0 is bits [3:0].
- BIN_W, 7, binary output width. Must satisfy 10^DIGITS − 1 < 2^BIN_W; the bench checks this at elaboration.

Ports:
- clk2  input  1  single system clock, rising-edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request to convert; sampled only while idle.
- bcd_in  input  4*DIGITS  packed BCD operand; sampled on the accepting edge only.
- busy  output  1  high while a conversion is in progress.
- done  output  1  one-cycle pulse when a result (or an error) is available.
- err  output  1  high when the last accepted operand had any digit > 9; valid with done.
- bin_out  output  BIN_W  result of the last conversion; held until the next completion.

Behaviour:
- Clock and reset: one clock, clk2. Reset is synchronous and active-high (rst), sampled on the rising edge of clk2.
- Reset state: FSM in IDLE; busy=0, done=0, err=0, bin_out=0; scratch registers and counter cleared.
- Reset mid-conversion: abort immediately. No done pulse, and bin_out is forced to 0.
- FSM states: IDLE, SHIFT.
- IDLE, start=1, all digits ≤ 9 (call this edge E0):
  - load scratch ← bcd_in, acc ← 0, cnt ← BIN_W;
  - busy ← 1, err ← 0;
  - go to SHIFT.
- IDLE, start=1, any digit > 9:
  - at E0: err ← 1, done ← 1 (one cycle), bin_out ← 0;
  - stay in IDLE;
  - error latency is 1 cycle.
- SHIFT, each edge:
  - {scratch, acc} ← {scratch, acc} >> 1;
  - then, for every 4-bit digit of the shifted scratch: if digit ≥ 8, subtract 3;
  - cnt ← cnt − 1.
- SHIFT, when the edge performs the last shift (cnt=1):
  - bin_out ← final acc (the shifted value);
  - done ← 1, busy ← 0;
  - return to IDLE.
- Latency: start sampled at E0, so done is high in the cycle after edge E0+BIN_W. For BIN_W=7, done is asserted exactly 7 cycles after the accepting edge. busy is high for cycles E0 … E0+BIN_W−1.
- done: single-cycle pulse, never high two consecutive cycles for the same operation.
- err and bin_out: hold their values until the next completion (either a done pulse or an error).
- start while busy=1: ignored; the operand is not re-sampled.
- start in the same cycle done=1: FSM is already in IDLE, so the request is accepted (back-to-back throughput of BIN_W cycles).
- start held high continuously: a new conversion starts every time the FSM is in IDLE.
- bcd_in changes during SHIFT: no effect on the result.
- Width rules: scratch is 4*DIGITS bits and acc is BIN_W bits. Digit correction subtracts 3 within 4 bits; no borrow crosses digits because a corrected digit is always ≥ 8. Result is exact for all valid inputs 0 … 10^DIGITS − 1.

Test Plan:
- Defaults (DIGITS=2, BIN_W=7); rst=1 for 2 cycles, then release → busy=0, done=0, err=0, bin_out=0.
- start=1 for 1 cycle, bcd_in=8'h42 → busy high 7 cycles; done=1 exactly 7 cycles after the accepting edge; bin_out=7'd42 (0101010), err=0; bin_out still 42 ten cycles later.
- Boundary operands, one conversion each:
  - bcd_in=8'h99 → bin_out=7'd99 (1100011);
  - bcd_in=8'h00 → bin_out=0;
  - bcd_in=8'h09 → bin_out=9;
  - bcd_in=8'h10 → bin_out=10.
- bcd_in=8'h3A, start=1 → next cycle done=1, err=1, bin_out=0, busy never asserted. Then a conversion of 8'h15 → err=0, bin_out=15.
- Start 8'h27; on cycle 3 of busy, pulse start with 8'h88 → ignored, bin_out=27. Then issue start=1 with 8'h88 in the cycle done=1 → accepted, next done gives 88, with no idle gap.
- Start 8'h64; assert rst on cycle 4 of busy → next cycle busy=0, done=0, bin_out=0, and no done pulse follows. A subsequent conversion of 8'h64 → bin_out=64.
- Exhaustive sweep of all 100 valid 2-digit codes against a reference model → all match, each with latency 7.

Source files
------------

// File: rtl/bcd_to_bin_if.sv
// Start/busy/done handshake bundle between a requester and the BCD-to-binary converter.
// The requester (master) drives start/bcd_in; the converter (slave) returns status and result.
interface bcd_to_bin_if #(
    parameter int DIGITS = 2,
    parameter int BIN_W  = 7
);
    logic                  start;
    logic [4*DIGITS-1:0]   bcd_in;
    logic                  busy;
    logic                  done;
    logic                  err;
    logic [BIN_W-1:0]      bin_out;

    modport master (
        output start, bcd_in,
        input  busy, done, err, bin_out
    );

    modport slave (
        input  start, bcd_in,
        output busy, done, err, bin_out
    );
endinterface

// File: rtl/bcd_to_bin.sv
// Packed BCD to unsigned binary via reverse double-dabble, one result bit per clock.
// Latency: done pulses BIN_W cycles after the accepting edge (1 cycle for an invalid digit).
// Backpressure: start is ignored while busy; a start coincident with done is accepted.
module bcd_to_bin #(
    parameter int DIGITS = 2,
    parameter int BIN_W  = 7
) (
    input  logic       clk2,
    input  logic       rst,
    bcd_to_bin_if.slave bus
);
    localparam int SW    = 4 * DIGITS;
    localparam int CNT_W = $clog2(BIN_W + 1);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [SW-1:0]      scratch_q, scratch_d;
    logic [BIN_W-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               err_q, err_d;
    logic [BIN_W-1:0]   bin_q, bin_d;

    logic               bad_digit;
    logic [SW+BIN_W-1:0] shifted;
    logic [SW-1:0]      corrected;

    always_comb begin
        bad_digit = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (bus.bcd_in[4*i +: 4] > 4'd9) begin
                bad_digit = 1'b1;
            end
        end
    end

    // A shifted digit >= 8 means a ten leaked in from the digit above; -3 restores it.
    always_comb begin
        shifted   = {scratch_q, acc_q} >> 1;
        corrected = shifted[SW+BIN_W-1:BIN_W];
        for (int i = 0; i < DIGITS; i++) begin
            if (shifted[BIN_W + 4*i + 3]) begin
                corrected[4*i +: 4] = shifted[BIN_W + 4*i +: 4] - 4'd3;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        scratch_d = scratch_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        err_d     = err_q;
        bin_d     = bin_q;

        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    if (bad_digit) begin
                        err_d  = 1'b1;
                        done_d = 1'b1;
                        bin_d  = '0;
                    end else begin
                        scratch_d = bus.bcd_in;
                        acc_d     = '0;
                        cnt_d     = CNT_W'(BIN_W);
                        busy_d    = 1'b1;
                        err_d     = 1'b0;
                        state_d   = SHIFT;
                    end
                end
            end
            SHIFT: begin
                scratch_d = corrected;
                acc_d     = shifted[BIN_W-1:0];
                cnt_d     = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    bin_d   = shifted[BIN_W-1:0];
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk2) begin
        if (rst) begin
            state_q   <= IDLE;
            scratch_q <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            bin_q     <= '0;
        end else begin
            state_q   <= state_d;
            scratch_q <= scratch_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            err_q     <= err_d;
            bin_q     <= bin_d;
        end
    end

    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.err     = err_q;
    assign bus.bin_out = bin_q;
endmodule

// File: tb/tb_bcd_to_bin.sv
// Bench for bcd_to_bin: directed scenarios plus random and exhaustive operands against a decimal model.
module tb_bcd_to_bin;
    localparam int DIGITS = 2;
    localparam int BIN_W  = 7;

    logic clk2 = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    always #5 clk2 = ~clk2;

    bcd_to_bin_if #(.DIGITS(DIGITS), .BIN_W(BIN_W)) bus ();

    bcd_to_bin #(.DIGITS(DIGITS), .BIN_W(BIN_W)) dut (
        .clk2 (clk2),
        .rst  (rst),
        .bus  (bus)
    );

    initial begin
        if (10**DIGITS - 1 >= 2**BIN_W) begin
            $display("FAIL param_check BIN_W=%0d too narrow for DIGITS=%0d", BIN_W, DIGITS);
            $fatal(1, "parameter check");
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // Decimal reference: digits weighted by powers of ten, invalid if any digit exceeds 9.
    function automatic logic ref_bad(input logic [7:0] v);
        return (v[7:4] > 4'd9) || (v[3:0] > 4'd9);
    endfunction

    function automatic int ref_val(input logic [7:0] v);
        return int'(v[7:4]) * 10 + int'(v[3:0]);
    endfunction

    function automatic logic [7:0] to_bcd(input int n);
        logic [3:0] hi;
        logic [3:0] lo;
        hi = 4'(n / 10);
        lo = 4'(n % 10);
        return {hi, lo};
    endfunction

    // Drives one request from a negedge; returns edges from accept to done and busy cycles seen.
    task automatic run_conv(input logic [7:0] v, output int lat, output int busy_n,
                            output logic err_o, output logic [BIN_W-1:0] bin_o);
        bus.bcd_in = v;
        bus.start  = 1'b1;
        @(negedge clk2);
        bus.start  = 1'b0;
        lat    = 0;
        busy_n = 0;
        while (!bus.done && lat < 40) begin
            if (bus.busy) busy_n++;
            @(negedge clk2);
            lat++;
        end
        err_o = bus.err;
        bin_o = bus.bin_out;
    endtask

    task automatic test_reset();
        rst        = 1'b1;
        bus.start  = 1'b0;
        bus.bcd_in = '0;
        repeat (2) @(negedge clk2);
        rst = 1'b0;
        checks++;
        if ({bus.busy, bus.done, bus.err} !== 3'b000 || bus.bin_out !== 7'd0) begin
            errors++;
            $display("FAIL reset_state busy=%b done=%b err=%b bin=%0d expected all 0",
                     bus.busy, bus.done, bus.err, bus.bin_out);
        end
    endtask

    task automatic test_basic();
        int lat, busy_n;
        logic e;
        logic [BIN_W-1:0] b;
        run_conv(8'h42, lat, busy_n, e, b);
        checks++;
        if (lat !== 7 || busy_n !== 7) begin
            errors++;
            $display("FAIL basic_latency lat=%0d busy_cycles=%0d expected 7/7", lat, busy_n);
        end
        checks++;
        if (b !== 7'd42 || e !== 1'b0) begin
            errors++;
            $display("FAIL basic_value bin=%0d err=%b expected 42/0", b, e);
        end
        @(negedge clk2);
        checks++;
        if (bus.done !== 1'b0) begin
            errors++;
            $display("FAIL done_single_pulse done=%b expected 0", bus.done);
        end
        repeat (10) @(negedge clk2);
        checks++;
        if (bus.bin_out !== 7'd42 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL basic_hold bin=%0d busy=%b expected 42/0", bus.bin_out, bus.busy);
        end
    endtask

    task automatic test_boundary();
        logic [7:0] ops [4];
        int lat, busy_n;
        logic e;
        logic [BIN_W-1:0] b;
        ops[0] = 8'h99;
        ops[1] = 8'h00;
        ops[2] = 8'h09;
        ops[3] = 8'h10;
        for (int i = 0; i < 4; i++) begin
            run_conv(ops[i], lat, busy_n, e, b);
            checks++;
            if (lat !== 7 || e !== 1'b0 || int'(b) !== ref_val(ops[i])) begin
                errors++;
                $display("FAIL boundary_%h lat=%0d err=%b bin=%0d expected 7/0/%0d",
                         ops[i], lat, e, b, ref_val(ops[i]));
            end
        end
    endtask

    task automatic test_error();
        int lat, busy_n;
        logic e;
        logic [BIN_W-1:0] b;
        run_conv(8'h3A, lat, busy_n, e, b);
        checks++;
        if (lat !== 0 || e !== 1'b1 || b !== 7'd0 || busy_n !== 0 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL error_code lat=%0d err=%b bin=%0d busy_cycles=%0d expected 0/1/0/0",
                     lat, e, b, busy_n);
        end
        @(negedge clk2);
        checks++;
        if (bus.done !== 1'b0 || bus.err !== 1'b1) begin
            errors++;
            $display("FAIL error_pulse done=%b err=%b expected 0/1", bus.done, bus.err);
        end
        run_conv(8'h15, lat, busy_n, e, b);
        checks++;
        if (lat !== 7 || e !== 1'b0 || b !== 7'd15) begin
            errors++;
            $display("FAIL after_error lat=%0d err=%b bin=%0d expected 7/0/15", lat, e, b);
        end
    endtask

    task automatic test_back_to_back();
        int lat;
        bus.bcd_in = 8'h27;
        bus.start  = 1'b1;
        @(negedge clk2);
        bus.start = 1'b0;
        lat = 0;
        repeat (2) begin
            @(negedge clk2);
            lat++;
        end
        bus.start  = 1'b1;
        bus.bcd_in = 8'h88;
        @(negedge clk2);
        lat++;
        bus.start = 1'b0;
        while (!bus.done && lat < 40) begin
            @(negedge clk2);
            lat++;
        end
        checks++;
        if (lat !== 7 || bus.bin_out !== 7'd27 || bus.err !== 1'b0) begin
            errors++;
            $display("FAIL start_while_busy lat=%0d bin=%0d err=%b expected 7/27/0",
                     lat, bus.bin_out, bus.err);
        end
        bus.start  = 1'b1;
        bus.bcd_in = 8'h88;
        @(negedge clk2);
        bus.start = 1'b0;
        checks++;
        if (bus.busy !== 1'b1 || bus.done !== 1'b0) begin
            errors++;
            $display("FAIL back_to_back_accept busy=%b done=%b expected 1/0", bus.busy, bus.done);
        end
        lat = 0;
        while (!bus.done && lat < 40) begin
            @(negedge clk2);
            lat++;
        end
        checks++;
        if (lat !== 7 || bus.bin_out !== 7'd88) begin
            errors++;
            $display("FAIL back_to_back_value lat=%0d bin=%0d expected 7/88", lat, bus.bin_out);
        end
    endtask

    task automatic test_reset_mid();
        int lat, busy_n;
        logic e;
        logic [BIN_W-1:0] b;
        logic seen;
        bus.bcd_in = 8'h64;
        bus.start  = 1'b1;
        @(negedge clk2);
        bus.start = 1'b0;
        repeat (3) @(negedge clk2);
        rst = 1'b1;
        @(negedge clk2);
        rst = 1'b0;
        checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.bin_out !== 7'd0) begin
            errors++;
            $display("FAIL reset_abort busy=%b done=%b bin=%0d expected 0/0/0",
                     bus.busy, bus.done, bus.bin_out);
        end
        seen = 1'b0;
        repeat (12) begin
            @(negedge clk2);
            if (bus.done) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin
            errors++;
            $display("FAIL reset_no_done done_seen=%b expected 0", seen);
        end
        run_conv(8'h64, lat, busy_n, e, b);
        checks++;
        if (lat !== 7 || e !== 1'b0 || b !== 7'd64) begin
            errors++;
            $display("FAIL after_reset lat=%0d err=%b bin=%0d expected 7/0/64", lat, e, b);
        end
    endtask

    task automatic test_random();
        int lat, busy_n;
        logic e;
        logic [BIN_W-1:0] b;
        logic [7:0] v;
        for (int i = 0; i < 30; i++) begin
            v = 8'($urandom_range(0, 255));
            run_conv(v, lat, busy_n, e, b);
            checks++;
            if (ref_bad(v)) begin
                if (lat !== 0 || e !== 1'b1 || b !== 7'd0) begin
                    errors++;
                    $display("FAIL random_bad_%h lat=%0d err=%b bin=%0d expected 0/1/0", v, lat, e, b);
                end
            end else if (lat !== 7 || e !== 1'b0 || int'(b) !== ref_val(v)) begin
                errors++;
                $display("FAIL random_ok_%h lat=%0d err=%b bin=%0d expected 7/0/%0d",
                         v, lat, e, b, ref_val(v));
            end
        end
    endtask

    task automatic test_sweep();
        int lat, busy_n;
        logic e;
        logic [BIN_W-1:0] b;
        for (int n = 0; n < 100; n++) begin
            run_conv(to_bcd(n), lat, busy_n, e, b);
            checks++;
            if (lat !== 7 || e !== 1'b0 || int'(b) !== n) begin
                errors++;
                $display("FAIL sweep_%0d lat=%0d err=%b bin=%0d expected 7/0/%0d", n, lat, e, b, n);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_boundary();
        test_error();
        test_back_to_back();
        test_reset_mid();
        test_random();
        test_sweep();
        repeat (2) @(negedge clk2);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
